// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU operation sequencer: ALU op codes,
// RV32I opcode/funct fields handled by the decoder, and sequencer FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_XOR = 3'b010,
        ALU_ADD = 3'b011,
        ALU_SUB = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I decoder for the subset the ALU sequencer supports:
// R/I-type logic, add/sub and shifts, plus beq/bne. Anything else is illegal.
module alu_decoder
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output alu_op_t         alu_op,
    output logic            use_imm,
    output logic [XLEN-1:0] imm,
    output logic            is_shift,
    output logic            is_branch,
    output logic            branch_ne,
    output logic            illegal,
    output logic            wb_en
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       unused_rs1_field;

    assign opcode           = instr[6:0];
    assign funct3           = instr[14:12];
    assign funct7           = instr[31:25];
    assign rd               = instr[11:7];
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alu_op    = ALU_ADD;
        use_imm   = 1'b0;
        imm       = {{(XLEN-12){instr[31]}}, instr[31:20]};
        is_shift  = 1'b0;
        is_branch = 1'b0;
        branch_ne = 1'b0;
        illegal   = 1'b1;

        case (opcode)
            OP_R: begin
                case (funct3)
                    F3_ADD_SUB: begin
                        if (funct7 == F7_BASE) begin
                            alu_op  = ALU_ADD;
                            illegal = 1'b0;
                        end else if (funct7 == F7_ALT) begin
                            alu_op  = ALU_SUB;
                            illegal = 1'b0;
                        end
                    end
                    F3_SLL: begin
                        alu_op   = ALU_SLL;
                        is_shift = 1'b1;
                        illegal  = (funct7 != F7_BASE);
                    end
                    F3_XOR: begin
                        alu_op  = ALU_XOR;
                        illegal = (funct7 != F7_BASE);
                    end
                    F3_SRL_SRA: begin
                        is_shift = 1'b1;
                        if (funct7 == F7_BASE) begin
                            alu_op  = ALU_SRL;
                            illegal = 1'b0;
                        end else if (funct7 == F7_ALT) begin
                            alu_op  = ALU_SRA;
                            illegal = 1'b0;
                        end
                    end
                    F3_OR: begin
                        alu_op  = ALU_OR;
                        illegal = (funct7 != F7_BASE);
                    end
                    F3_AND: begin
                        alu_op  = ALU_AND;
                        illegal = (funct7 != F7_BASE);
                    end
                    default: ;
                endcase
            end
            OP_I: begin
                use_imm = 1'b1;
                case (funct3)
                    F3_ADD_SUB: begin
                        alu_op  = ALU_ADD;
                        illegal = 1'b0;
                    end
                    F3_XOR: begin
                        alu_op  = ALU_XOR;
                        illegal = 1'b0;
                    end
                    F3_OR: begin
                        alu_op  = ALU_OR;
                        illegal = 1'b0;
                    end
                    F3_AND: begin
                        alu_op  = ALU_AND;
                        illegal = 1'b0;
                    end
                    F3_SLL: begin
                        alu_op   = ALU_SLL;
                        is_shift = 1'b1;
                        imm      = {{(XLEN-5){1'b0}}, instr[24:20]};
                        illegal  = (funct7 != F7_BASE);
                    end
                    F3_SRL_SRA: begin
                        is_shift = 1'b1;
                        imm      = {{(XLEN-5){1'b0}}, instr[24:20]};
                        if (funct7 == F7_BASE) begin
                            alu_op  = ALU_SRL;
                            illegal = 1'b0;
                        end else if (funct7 == F7_ALT) begin
                            alu_op  = ALU_SRA;
                            illegal = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            OP_BRANCH: begin
                alu_op    = ALU_SUB;
                is_branch = 1'b1;
                if (funct3 == F3_BEQ) begin
                    illegal = 1'b0;
                end else if (funct3 == F3_BNE) begin
                    branch_ne = 1'b1;
                    illegal   = 1'b0;
                end
            end
            default: ;
        endcase

        wb_en = !illegal && !is_branch && (rd != 5'd0);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one decoded RV32I instruction through the external combinational
// ALU: accept request, drive operands for one cycle, return captured result.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_instr,
    input  logic [XLEN-1:0] req_rs1_data,
    input  logic [XLEN-1:0] req_rs2_data,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_control,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic [4:0]      rsp_rd,
    output logic            rsp_wb_en,
    output logic            rsp_branch_taken,
    output logic            rsp_illegal
);

    alu_op_t         dec_alu_op;
    logic            dec_use_imm;
    logic [XLEN-1:0] dec_imm;
    logic            dec_is_shift;
    logic            dec_is_branch;
    logic            dec_branch_ne;
    logic            dec_illegal;
    logic            dec_wb_en;
    logic [XLEN-1:0] operand_b;

    seq_state_t      state_q, state_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    alu_op_t         alu_op_q, alu_op_d;
    logic [4:0]      rd_q, rd_d;
    logic            wb_pend_q, wb_pend_d;
    logic            is_branch_q, is_branch_d;
    logic            branch_ne_q, branch_ne_d;
    logic [XLEN-1:0] rsp_result_q, rsp_result_d;
    logic            rsp_wb_en_q, rsp_wb_en_d;
    logic            rsp_taken_q, rsp_taken_d;
    logic            rsp_illegal_q, rsp_illegal_d;

    alu_decoder #(.XLEN(XLEN)) u_decoder (
        .instr     (req_instr),
        .alu_op    (dec_alu_op),
        .use_imm   (dec_use_imm),
        .imm       (dec_imm),
        .is_shift  (dec_is_shift),
        .is_branch (dec_is_branch),
        .branch_ne (dec_branch_ne),
        .illegal   (dec_illegal),
        .wb_en     (dec_wb_en)
    );

    // Shift amounts only ever reach the ALU as a 5-bit zero-extended value.
    always_comb begin
        operand_b = dec_use_imm ? dec_imm : req_rs2_data;
        if (dec_is_shift) begin
            operand_b[XLEN-1:5] = '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        rd_d          = rd_q;
        wb_pend_d     = wb_pend_q;
        is_branch_d   = is_branch_q;
        branch_ne_d   = branch_ne_q;
        rsp_result_d  = rsp_result_q;
        rsp_wb_en_d   = rsp_wb_en_q;
        rsp_taken_d   = rsp_taken_q;
        rsp_illegal_d = rsp_illegal_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rd_d = req_instr[11:7];
                    if (dec_illegal) begin
                        rsp_result_d  = '0;
                        rsp_wb_en_d   = 1'b0;
                        rsp_taken_d   = 1'b0;
                        rsp_illegal_d = 1'b1;
                        state_d       = S_RESP;
                    end else begin
                        alu_a_d     = req_rs1_data;
                        alu_b_d     = operand_b;
                        alu_op_d    = dec_alu_op;
                        wb_pend_d   = dec_wb_en;
                        is_branch_d = dec_is_branch;
                        branch_ne_d = dec_branch_ne;
                        state_d     = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                rsp_result_d  = alu_result;
                rsp_wb_en_d   = wb_pend_q;
                rsp_taken_d   = is_branch_q && (alu_zero ^ branch_ne_q);
                rsp_illegal_d = 1'b0;
                state_d       = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= ALU_AND;
            rd_q          <= '0;
            wb_pend_q     <= 1'b0;
            is_branch_q   <= 1'b0;
            branch_ne_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_wb_en_q   <= 1'b0;
            rsp_taken_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            rd_q          <= rd_d;
            wb_pend_q     <= wb_pend_d;
            is_branch_q   <= is_branch_d;
            branch_ne_q   <= branch_ne_d;
            rsp_result_q  <= rsp_result_d;
            rsp_wb_en_q   <= rsp_wb_en_d;
            rsp_taken_q   <= rsp_taken_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign req_ready        = (state_q == S_IDLE);
    assign rsp_valid        = (state_q == S_RESP);
    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign alu_control      = alu_op_q;
    assign rsp_result       = rsp_result_q;
    assign rsp_rd           = rd_q;
    assign rsp_wb_en        = rsp_wb_en_q;
    assign rsp_branch_taken = rsp_taken_q;
    assign rsp_illegal      = rsp_illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: directed RV32I cases plus randomized instructions
// compared against an instruction-level reference model.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_rs1_data;
    logic [31:0] req_rs2_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_rd;
    logic        rsp_wb_en;
    logic        rsp_branch_taken;
    logic        rsp_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_sequencer #(.XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_instr        (req_instr),
        .req_rs1_data     (req_rs1_data),
        .req_rs2_data     (req_rs2_data),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_control      (alu_control),
        .alu_result       (alu_result),
        .alu_zero         (alu_zero),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_result       (rsp_result),
        .rsp_rd           (rsp_rd),
        .rsp_wb_en        (rsp_wb_en),
        .rsp_branch_taken (rsp_branch_taken),
        .rsp_illegal      (rsp_illegal)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational ALU the sequencer drives.
    always_comb begin
        alu_result = 32'h0;
        case (alu_control)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: alu_result = alu_a ^ alu_b;
            3'b011: alu_result = alu_a + alu_b;
            3'b100: alu_result = alu_a - alu_b;
            3'b101: alu_result = alu_a << alu_b[4:0];
            3'b110: alu_result = alu_a >> alu_b[4:0];
            3'b111: alu_result = $signed(alu_a) >>> alu_b[4:0];
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    typedef struct {
        bit          legal;
        logic [31:0] result;
        bit          taken;
        bit          wb_en;
        logic [4:0]  rd;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of each supported instruction, straight from the ISA.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] rs1,
                                       input logic [31:0] rs2);
        exp_t        e;
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        logic [31:0] imm = {{20{ins[31]}}, ins[31:20]};
        logic [4:0]  sh  = ins[24:20];
        bit          is_alu = 1'b0;
        e.legal  = 1'b0;
        e.result = 32'h0;
        e.taken  = 1'b0;
        e.rd     = ins[11:7];
        if (opc == 7'b0110011) begin
            is_alu = 1'b1;
            if (f7 == 7'h00 && f3 != 3'd2 && f3 != 3'd3) e.legal = 1'b1;
            if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.legal = 1'b1;
            case (f3)
                3'd0: e.result = (f7 == 7'h20) ? rs1 - rs2 : rs1 + rs2;
                3'd1: e.result = rs1 << rs2[4:0];
                3'd4: e.result = rs1 ^ rs2;
                3'd5: e.result = (f7 == 7'h20) ? 32'($signed(rs1) >>> rs2[4:0]) : rs1 >> rs2[4:0];
                3'd6: e.result = rs1 | rs2;
                3'd7: e.result = rs1 & rs2;
                default: e.result = 32'h0;
            endcase
        end else if (opc == 7'b0010011) begin
            is_alu = 1'b1;
            case (f3)
                3'd0: begin e.legal = 1'b1; e.result = rs1 + imm; end
                3'd4: begin e.legal = 1'b1; e.result = rs1 ^ imm; end
                3'd6: begin e.legal = 1'b1; e.result = rs1 | imm; end
                3'd7: begin e.legal = 1'b1; e.result = rs1 & imm; end
                3'd1: begin e.legal = (f7 == 7'h00); e.result = rs1 << sh; end
                3'd5: begin
                    e.legal  = (f7 == 7'h00) || (f7 == 7'h20);
                    e.result = (f7 == 7'h20) ? 32'($signed(rs1) >>> sh) : rs1 >> sh;
                end
                default: e.legal = 1'b0;
            endcase
        end else if (opc == 7'b1100011) begin
            e.legal  = (f3 == 3'd0) || (f3 == 3'd1);
            e.result = rs1 - rs2;
            e.taken  = (rs1 == rs2) != f3[0];
        end
        e.wb_en = e.legal && is_alu && (e.rd != 5'd0);
        if (!e.legal) begin
            e.result = 32'h0;
            e.taken  = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 8 && req_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (req_ready !== 1'b1) check("req_ready_timeout", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic run_txn(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2,
                           input int hold, input bit chk_alu, input logic [2:0] exp_ctl,
                           input logic [31:0] exp_b);
        exp_t e = ref_model(ins, rs1, rs2);
        wait_ready();
        req_valid    = 1'b1;
        req_instr    = ins;
        req_rs1_data = rs1;
        req_rs2_data = rs2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (e.legal) begin
            check("exec_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            check("exec_req_ready", {31'h0, req_ready}, 32'h0);
            check("exec_alu_a", alu_a, rs1);
            if (chk_alu) begin
                check("exec_alu_control", {29'h0, alu_control}, {29'h0, exp_ctl});
                check("exec_alu_b", alu_b, exp_b);
            end
            @(posedge clk); #1;
        end
        check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("rsp_result", rsp_result, e.result);
        check("rsp_rd", {27'h0, rsp_rd}, {27'h0, e.rd});
        check("rsp_wb_en", {31'h0, rsp_wb_en}, {31'h0, e.wb_en});
        check("rsp_taken", {31'h0, rsp_branch_taken}, {31'h0, e.taken});
        check("rsp_illegal", {31'h0, rsp_illegal}, {31'h0, !e.legal});
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            req_valid    = 1'b1;
            req_instr    = 32'h002081B3;
            req_rs1_data = $urandom;
            req_rs2_data = $urandom;
            @(posedge clk); #1;
            check("hold_req_ready", {31'h0, req_ready}, 32'h0);
            check("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("hold_rsp_result", rsp_result, e.result);
            check("hold_rsp_rd", {27'h0, rsp_rd}, {27'h0, e.rd});
            check("hold_rsp_wb_en", {31'h0, rsp_wb_en}, {31'h0, e.wb_en});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("done_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("done_req_ready", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        check({pfx, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        check({pfx, "_rsp_result"}, rsp_result, 32'h0);
        check({pfx, "_rsp_rd"}, {27'h0, rsp_rd}, 32'h0);
        check({pfx, "_rsp_flags"}, {29'h0, rsp_wb_en, rsp_branch_taken, rsp_illegal}, 32'h0);
        check({pfx, "_alu_a"}, alu_a, 32'h0);
        check({pfx, "_alu_b"}, alu_b, 32'h0);
        check({pfx, "_alu_control"}, {29'h0, alu_control}, 32'h0);
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_instr    = 32'h0;
        req_rs1_data = 32'h0;
        req_rs2_data = 32'h0;
        rsp_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("reset");

        // add x3,x1,x2
        run_txn(32'h002081B3, 32'd7, 32'd5, 0, 1'b1, 3'b011, 32'd5);
        // srai x5,x6,4
        run_txn(32'h40435293, 32'h80000000, 32'h0, 1, 1'b1, 3'b111, 32'd4);
        // beq / bne x1,x2 with equal operands
        run_txn(32'h00208063, 32'h1234, 32'h1234, 0, 1'b1, 3'b100, 32'h1234);
        run_txn(32'h00209063, 32'h1234, 32'h1234, 0, 1'b1, 3'b100, 32'h1234);
        // sll x4,x1,x2: only rs2[4:0] reaches the ALU
        run_txn(32'h00209233, 32'h1, 32'hFFFF_FFE3, 0, 1'b1, 3'b101, 32'd3);
        // slt and a load opcode are illegal
        run_txn(32'h0020A1B3, 32'd1, 32'd2, 0, 1'b0, 3'b000, 32'h0);
        run_txn(32'h0000A183, 32'd1, 32'd2, 0, 1'b0, 3'b000, 32'h0);
        // response back-pressure for 5 cycles
        run_txn(32'h002081B3, 32'hFFFF_FFFF, 32'd1, 5, 1'b1, 3'b011, 32'd1);

        for (int n = 0; n < 60; n++) begin
            int          sel = $urandom_range(0, 3);
            int          f7s = $urandom_range(0, 3);
            logic [6:0]  opc;
            logic [6:0]  f7;
            logic [31:0] ins;
            logic [31:0] a = $urandom;
            logic [31:0] b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            opc = (sel == 0) ? 7'b0110011 : (sel == 1) ? 7'b0010011 :
                  (sel == 2) ? 7'b1100011 : 7'($urandom);
            f7  = (f7s == 0) ? 7'h00 : (f7s == 1) ? 7'h20 : 7'($urandom);
            ins = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
            run_txn(ins, a, b, $urandom_range(0, 2), 1'b0, 3'b000, 32'h0);
        end

        // Reset while in EXEC drops the transaction.
        wait_ready();
        req_valid    = 1'b1;
        req_instr    = 32'h002081B3;
        req_rs1_data = 32'd9;
        req_rs2_data = 32'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_exec", {31'h0, rsp_valid}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        rsp_ready = 1'b1;
        check_reset_values("abort");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", {31'h0, rsp_valid}, 32'h0);
        end
        rsp_ready = 1'b0;

        run_txn(32'h002081B3, 32'd7, 32'd5, 0, 1'b1, 3'b011, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
